// File: rtl/rvfi_retire_checker_if.sv
// RVFI retirement bus as produced by the core and consumed by the checker.
//   master : the RVFI producer (core or testbench driver), drives every signal
//   slave  : the RVFI consumer (rvfi_retire_checker), samples every signal
// Handshake: rvfi_valid is a one-way strobe with no back-pressure. When it is
// high, every other signal describes exactly one retired instruction in that
// cycle. When it is low, the remaining signals are ignored.
interface rvfi_retire_checker_if;
   logic        rvfi_valid;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic        rvfi_halt;
   logic [4:0]  rvfi_rs1_addr;
   logic [4:0]  rvfi_rs2_addr;
   logic [31:0] rvfi_rs1_rdata;
   logic [31:0] rvfi_rs2_rdata;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic [31:0] rvfi_pc_rdata;
   logic [31:0] rvfi_pc_wdata;
   logic [3:0]  rvfi_mem_rmask;
   logic [3:0]  rvfi_mem_wmask;

   modport master (
      output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
             rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_mem_rmask, rvfi_mem_wmask
   );

   modport slave (
      input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
             rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_mem_rmask, rvfi_mem_wmask
   );
endinterface

// File: rtl/rvfi_retire_checker.sv
// Consistency checker for an RVFI retirement stream. It keeps a shadow copy
// of the architectural register file built from retired writes and checks
// each retirement for order sequence, PC continuity, x0 semantics, operand
// readback, memory-mask sanity and retire-after-halt. The first violation
// is latched stickily together with its rvfi_order.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   rvfi           : RVFI retirement bus (slave modport)
//   err_o          : sticky error flag
//   err_code_o     : code of the first error (1 ORDER .. 7 HALT)
//   err_order_o    : rvfi_order of the first failing retirement
//   retire_cnt_o   : clean retirements accepted, saturating
//   state_o        : 0 IDLE, 1 RUN, 2 HALTED, 3 ERROR
// All outputs are registered: a result appears one cycle after its valid.
module rvfi_retire_checker #(
   parameter int unsigned CHECK_REGS = 1,
   parameter int unsigned CHECK_PC   = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   rvfi_retire_checker_if.slave rvfi,
   output logic                 err_o,
   output logic [3:0]           err_code_o,
   output logic [63:0]          err_order_o,
   output logic [CNT_W-1:0]     retire_cnt_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [63:0]       prev_order_q;
   logic [31:0]       prev_pc_q;
   logic              err_q;
   logic [3:0]        err_code_q;
   logic [63:0]       err_order_q;
   logic [CNT_W-1:0]  retire_cnt_q;

   // A retirement is only looked at outside ERROR; ERROR freezes everything.
   logic accept;
   assign accept = rvfi.rvfi_valid && (state_q != ST_ERROR);

   // ---------------------------------------------------------------
   // Shadow register file. Reads return the contents from before this
   // cycle's write, so rd == rs1 in one instruction sees the old value.
   // ---------------------------------------------------------------
   logic        shadow_we;
   logic        rs1_known, rs2_known;
   logic [31:0] rs1_shadow, rs2_shadow;

   assign shadow_we = accept && !rvfi.rvfi_trap && (rvfi.rvfi_rd_addr != 5'd0);

   generate
      if (CHECK_REGS != 0) begin : g_shadow
         logic [31:0] shadow_q [32];
         logic [31:0] shadow_vld_q;  // bit 0 is never set: x0 has no shadow

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               shadow_vld_q <= '0;
            end else if (shadow_we) begin
               shadow_vld_q[rvfi.rvfi_rd_addr] <= 1'b1;
            end
         end

         // Data needs no reset: it is qualified by the valid bits.
         always_ff @(posedge clk_i) begin
            if (shadow_we) begin
               shadow_q[rvfi.rvfi_rd_addr] <= rvfi.rvfi_rd_wdata;
            end
         end

         assign rs1_known  = shadow_vld_q[rvfi.rvfi_rs1_addr];
         assign rs2_known  = shadow_vld_q[rvfi.rvfi_rs2_addr];
         assign rs1_shadow = shadow_q[rvfi.rvfi_rs1_addr];
         assign rs2_shadow = shadow_q[rvfi.rvfi_rs2_addr];
      end else begin : g_no_shadow
         assign rs1_known  = 1'b0;
         assign rs2_known  = 1'b0;
         assign rs1_shadow = '0;
         assign rs2_shadow = '0;
      end
   endgenerate

   // The instruction word is carried on the bus but not checked.
   logic unused_insn;
   assign unused_insn = ^rvfi.rvfi_insn;

   // ---------------------------------------------------------------
   // Individual checks
   // ---------------------------------------------------------------
   logic [63:0] next_order;
   logic        bad_order, bad_pc, bad_x0, bad_rs1, bad_rs2, bad_mem, bad_halt;

   assign next_order = prev_order_q + 64'd1;

   always_comb begin
      bad_order = 1'b0;
      if (state_q == ST_IDLE) begin
         bad_order = (rvfi.rvfi_order != 64'd0);
      end else if (state_q == ST_RUN) begin
         bad_order = (rvfi.rvfi_order != next_order);
      end
   end

   assign bad_pc   = (CHECK_PC != 0) && (state_q == ST_RUN) &&
                     (rvfi.rvfi_pc_rdata != prev_pc_q);
   assign bad_x0   = ((rvfi.rvfi_rd_addr  == 5'd0) && (rvfi.rvfi_rd_wdata  != 32'd0)) ||
                     ((rvfi.rvfi_rs1_addr == 5'd0) && (rvfi.rvfi_rs1_rdata != 32'd0)) ||
                     ((rvfi.rvfi_rs2_addr == 5'd0) && (rvfi.rvfi_rs2_rdata != 32'd0));
   assign bad_rs1  = (rvfi.rvfi_rs1_addr != 5'd0) && rs1_known &&
                     (rvfi.rvfi_rs1_rdata != rs1_shadow);
   assign bad_rs2  = (rvfi.rvfi_rs2_addr != 5'd0) && rs2_known &&
                     (rvfi.rvfi_rs2_rdata != rs2_shadow);
   assign bad_mem  = (rvfi.rvfi_mem_rmask != 4'd0) && (rvfi.rvfi_mem_wmask != 4'd0);
   assign bad_halt = (state_q == ST_HALTED);

   // Lowest code wins when several checks fail together.
   logic [3:0] hit_code;
   always_comb begin
      hit_code = 4'd0;
      if      (bad_order) hit_code = 4'd1;
      else if (bad_pc)    hit_code = 4'd2;
      else if (bad_x0)    hit_code = 4'd3;
      else if (bad_rs1)   hit_code = 4'd4;
      else if (bad_rs2)   hit_code = 4'd5;
      else if (bad_mem)   hit_code = 4'd6;
      else if (bad_halt)  hit_code = 4'd7;
   end

   logic hit;
   assign hit = accept && (hit_code != 4'd0);

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (hit_code != 4'd0) begin
            state_d = ST_ERROR;
         end else begin
            case (state_q)
               ST_IDLE: state_d = rvfi.rvfi_halt ? ST_HALTED : ST_RUN;
               ST_RUN:  state_d = rvfi.rvfi_halt ? ST_HALTED : ST_RUN;
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // History, error latch and retirement counter
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_order_q <= '0;
         prev_pc_q    <= '0;
         err_q        <= 1'b0;
         err_code_q   <= '0;
         err_order_q  <= '0;
         retire_cnt_q <= '0;
      end else if (accept) begin
         // Trapped instructions still advance order and PC history.
         prev_order_q <= rvfi.rvfi_order;
         prev_pc_q    <= rvfi.rvfi_pc_wdata;
         if (hit) begin
            err_q       <= 1'b1;
            err_code_q  <= hit_code;
            err_order_q <= rvfi.rvfi_order;
         end else if (retire_cnt_q != {CNT_W{1'b1}}) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
         end
      end
   end

   assign err_o        = err_q;
   assign err_code_o   = err_code_q;
   assign err_order_o  = err_order_q;
   assign retire_cnt_o = retire_cnt_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_rvfi_retire_checker.sv
module tb_rvfi_retire_checker;

   typedef struct packed {
      logic [63:0] order;
      logic        trap;
      logic        halt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] rdd;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [3:0]  rm;
      logic [3:0]  wm;
   } txn_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rvfi_retire_checker_if bus ();

   logic        err, err4;
   logic [3:0]  code, code4;
   logic [63:0] eorder, eorder4;
   logic [31:0] cnt;
   logic [3:0]  cnt4;
   logic [1:0]  st, st4;

   rvfi_retire_checker dut (
      .clk_i(clk), .rst_i(rst), .rvfi(bus.slave),
      .err_o(err), .err_code_o(code), .err_order_o(eorder),
      .retire_cnt_o(cnt), .state_o(st)
   );

   rvfi_retire_checker #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .rvfi(bus.slave),
      .err_o(err4), .err_code_o(code4), .err_order_o(eorder4),
      .retire_cnt_o(cnt4), .state_o(st4)
   );

   // ---------------- reference model ----------------
   // States: 0 idle (nothing retired), 1 running, 2 halted, 3 failed.
   int          m_state;
   logic        m_err;
   logic [3:0]  m_code;
   logic [63:0] m_eorder;
   logic [63:0] m_prev_order;
   logic [31:0] m_prev_pc;
   longint      m_cnt;
   int          m_cnt4;
   logic [31:0] m_regs[int];   // a key exists only once the register is known

   function automatic void model_reset();
      m_state = 0; m_err = 1'b0; m_code = '0; m_eorder = '0;
      m_prev_order = '0; m_prev_pc = '0; m_cnt = 0; m_cnt4 = 0;
      m_regs.delete();
   endfunction

   function automatic bit reg_mismatch(logic [4:0] a, logic [31:0] d);
      if (a == 0) return 1'b0;
      if (!m_regs.exists(int'(a))) return 1'b0;
      return m_regs[int'(a)] != d;
   endfunction

   function automatic void model_retire(txn_t t);
      int found[$];
      if (m_state == 3) return;
      if (m_state == 0 && t.order != 0) found.push_back(1);
      if (m_state == 1 && t.order != m_prev_order + 1) found.push_back(1);
      if (m_state == 1 && t.pc != m_prev_pc) found.push_back(2);
      if ((t.rd == 0 && t.rdd != 0) || (t.rs1 == 0 && t.rs1d != 0) ||
          (t.rs2 == 0 && t.rs2d != 0)) found.push_back(3);
      if (reg_mismatch(t.rs1, t.rs1d)) found.push_back(4);
      if (reg_mismatch(t.rs2, t.rs2d)) found.push_back(5);
      if (t.rm != 0 && t.wm != 0) found.push_back(6);
      if (m_state == 2) found.push_back(7);
      m_prev_order = t.order;
      m_prev_pc    = t.npc;
      if (found.size() > 0) begin
         found.sort();
         m_err = 1'b1; m_code = 4'(found[0]); m_eorder = t.order; m_state = 3;
      end else begin
         if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (m_cnt4 < 15) m_cnt4++;
         if (t.halt) m_state = 2;
         else if (m_state == 0) m_state = 1;
      end
      if (!t.trap && t.rd != 0) m_regs[int'(t.rd)] = t.rdd;
   endfunction

   // ---------------- scoreboard ----------------
   logic [70:0] exp_q[$];   // {state, err, code, err_order}
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare_all();
      logic [70:0] e;
      if (exp_q.size() == 0) begin
         check_eq("exp_q_empty", 64'd1, 64'd0);
         return;
      end
      e = exp_q.pop_front();
      check_eq("state",      64'(st),     64'(e[70:69]));
      check_eq("err",        64'(err),    64'(e[68]));
      check_eq("err_code",   64'(code),   64'(e[67:64]));
      check_eq("err_order",  eorder,      e[63:0]);
      check_eq("retire_cnt", 64'(cnt),    64'(m_cnt));
      check_eq("state4",     64'(st4),    64'(e[70:69]));
      check_eq("err_code4",  64'(code4),  64'(e[67:64]));
      check_eq("retire_cnt4",64'(cnt4),   64'(m_cnt4));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(bit v, txn_t t);
      bus.rvfi_valid     = v;
      bus.rvfi_order     = t.order;
      bus.rvfi_insn      = $urandom;
      bus.rvfi_trap      = t.trap;
      bus.rvfi_halt      = t.halt;
      bus.rvfi_rs1_addr  = t.rs1;
      bus.rvfi_rs2_addr  = t.rs2;
      bus.rvfi_rs1_rdata = t.rs1d;
      bus.rvfi_rs2_rdata = t.rs2d;
      bus.rvfi_rd_addr   = t.rd;
      bus.rvfi_rd_wdata  = t.rdd;
      bus.rvfi_pc_rdata  = t.pc;
      bus.rvfi_pc_wdata  = t.npc;
      bus.rvfi_mem_rmask = t.rm;
      bus.rvfi_mem_wmask = t.wm;
      if (v) model_retire(t);
      exp_q.push_back({2'(m_state), m_err, m_code, m_eorder});
      @(posedge clk);
      @(negedge clk);
      bus.rvfi_valid = 1'b0;
      compare_all();
   endtask

   task automatic do_reset();
      bus.rvfi_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      exp_q.push_back({2'd0, 1'b0, 4'd0, 64'd0});
      compare_all();
   endtask

   function automatic txn_t mk(logic [63:0] o, logic [31:0] pc);
      txn_t t;
      t = '0;
      t.order = o; t.pc = pc; t.npc = pc + 32'd4;
      return t;
   endfunction

   function automatic logic [31:0] pick_rdata(logic [4:0] a);
      if (a == 0) return 32'd0;
      if (m_regs.exists(int'(a))) return m_regs[int'(a)];
      return $urandom;
   endfunction

   function automatic txn_t gen_clean();
      txn_t t;
      t = '0;
      t.order = (m_state == 0) ? 64'd0 : m_prev_order + 64'd1;
      t.pc    = (m_state == 0) ? ($urandom & 32'hFFFF_FFFC) : m_prev_pc;
      t.npc   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : t.pc + 32'd4;
      t.rs1   = 5'($urandom_range(0, 7));
      t.rs2   = 5'($urandom_range(0, 7));
      t.rd    = 5'($urandom_range(0, 7));
      t.rs1d  = pick_rdata(t.rs1);
      t.rs2d  = pick_rdata(t.rs2);
      t.rdd   = (t.rd == 0) ? 32'd0 : $urandom;
      t.trap  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
         1: t.rm = 4'($urandom_range(1, 15));
         2: t.wm = 4'($urandom_range(1, 15));
         default: ;
      endcase
      return t;
   endfunction

   function automatic txn_t gen_random();
      txn_t t;
      t = gen_clean();
      case ($urandom_range(0, 24))
         1: t.order = t.order + 64'($urandom_range(1, 3));
         2: t.pc    = t.pc + 32'd4;
         3: begin t.rd = 5'd0; t.rdd = 32'd1; end
         4: t.rs1d  = t.rs1d ^ 32'h1;
         5: t.rs2d  = t.rs2d ^ 32'h8000_0000;
         6: begin t.rm = 4'hF; t.wm = 4'h1; end
         7: t.halt  = 1'b1;
         8: begin t.rs1 = 5'd0; t.rs1d = 32'd5; end
         9: begin t.rs2 = 5'd0; t.rs2d = 32'd7; end
         default: ;
      endcase
      return t;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      txn_t t;
      bus.rvfi_valid = 1'b0;
      model_reset();
      do_reset();

      // Clean stream with x1 = 5, x2 = x1 + x1.
      t = mk(0, 32'h0); t.rd = 5'd1; t.rdd = 32'd5; drive(1, t);
      t = mk(1, 32'h4); t.rs1 = 5'd1; t.rs2 = 5'd1; t.rs1d = 32'd5; t.rs2d = 32'd5;
      t.rd = 5'd2; t.rdd = 32'd10; drive(1, t);
      t = mk(2, 32'h8); drive(1, t);
      check_eq("clean_err", 64'(err), 64'd0);
      check_eq("clean_cnt", 64'(cnt), 64'd3);
      check_eq("clean_state", 64'(st), 64'd1);

      // Order gap 0,1,3.
      do_reset();
      drive(1, mk(0, 32'h0));
      drive(1, mk(1, 32'h4));
      drive(1, mk(3, 32'h8));
      check_eq("gap_code", 64'(code), 64'd1);
      check_eq("gap_order", eorder, 64'd3);
      check_eq("gap_cnt", 64'(cnt), 64'd2);
      check_eq("gap_state", 64'(st), 64'd3);
      drive(1, mk(4, 32'hC));   // ERROR is frozen
      check_eq("frozen_cnt", 64'(cnt), 64'd2);

      // Operand mismatch on rs2.
      do_reset();
      t = mk(0, 32'h0); t.rd = 5'd5; t.rdd = 32'hDEAD_BEEF; drive(1, t);
      t = mk(1, 32'h4); t.rs2 = 5'd5; t.rs2d = 32'hDEAD_BEEE; drive(1, t);
      check_eq("rs2_code", 64'(code), 64'd5);

      // rd == rs1 in one instruction compares against the old value.
      do_reset();
      t = mk(0, 32'h0); t.rd = 5'd5; t.rdd = 32'hDEAD_BEEF; drive(1, t);
      t = mk(1, 32'h4); t.rs1 = 5'd5; t.rs1d = 32'hDEAD_BEEF; t.rd = 5'd5; t.rdd = 32'd1;
      drive(1, t);
      t = mk(2, 32'h8); t.rs1 = 5'd5; t.rs1d = 32'd1; drive(1, t);
      check_eq("rdrs1_err", 64'(err), 64'd0);

      // X0 and PC failing together: PC wins.
      do_reset();
      drive(1, mk(0, 32'h0));
      t = mk(1, 32'h100); t.rd = 5'd0; t.rdd = 32'd1; drive(1, t);
      check_eq("multi_code", 64'(code), 64'd2);

      // Trapped write leaves x7 unknown.
      do_reset();
      t = mk(0, 32'h0); t.trap = 1'b1; t.rd = 5'd7; t.rdd = 32'h55; drive(1, t);
      t = mk(1, 32'h4); t.rs1 = 5'd7; t.rs1d = 32'h1234; drive(1, t);
      check_eq("trap_err", 64'(err), 64'd0);

      // Halt, then retire again, then reset out of ERROR.
      do_reset();
      t = mk(0, 32'h0); t.halt = 1'b1; drive(1, t);
      check_eq("halt_state", 64'(st), 64'd2);
      drive(1, mk(1, 32'h4));
      check_eq("halt_code", 64'(code), 64'd7);
      check_eq("halt_state2", 64'(st), 64'd3);
      do_reset();
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_state", 64'(st), 64'd0);

      // Both memory masks.
      t = mk(0, 32'h0); t.rm = 4'hF; t.wm = 4'h1; drive(1, t);
      check_eq("mem_code", 64'(code), 64'd6);

      // Counter saturation on the 4-bit instance.
      do_reset();
      for (int i = 0; i < 17; i++) drive(1, mk(64'(i), 32'(i * 4)));
      check_eq("cnt4_sat", 64'(cnt4), 64'hF);
      check_eq("cnt32_free", 64'(cnt), 64'd17);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ((m_state >= 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
            do_reset();
         else if ($urandom_range(0, 3) == 0)
            drive(0, gen_clean());
         else
            drive(1, gen_random());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
